// File: rtl/mul_issue_unit.sv
// Issue/conditioning stage around a 2-stage, CE-gated, unreset 33x33 multiplier.
// Carries valid/op/tag beside the multiplier stages and registers the chosen product half.
module mul_issue_unit #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_rs1,
  input  logic [31:0]      in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy,
  output logic [32:0]      mul_a,
  output logic [32:0]      mul_b,
  output logic             mul_ce,
  input  logic [65:0]      mul_p
);

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } op_e;

  op_e              op_in;
  op_e              op1, op2;
  logic [TAG_W-1:0] tag1, tag2;
  logic             v1, v2;
  logic             fire;
  logic             sign_a, sign_b;

  assign op_in    = op_e'(in_op);
  assign mul_ce   = ~(out_valid & ~out_ready);
  assign in_ready = mul_ce & ~flush;
  assign fire     = in_valid & in_ready;
  assign busy     = v1 | v2 | out_valid;

  // The 33rd bit turns the multiplier's signed product into the RV32M signedness mix.
  assign sign_a = (op_in != OP_MULHU);
  assign sign_b = (op_in == OP_MUL) || (op_in == OP_MULH);
  assign mul_a  = {sign_a & in_rs1[31], in_rs1};
  assign mul_b  = {sign_b & in_rs2[31], in_rs2};

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // the pre-edge value of the stage before it, matching the multiplier registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
    end else if (flush) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
    end else if (mul_ce) begin
      v1        <= fire;
      v2        <= v1;
      out_valid <= v2;
    end
  end

  // Payload follows the multiplier's CE; anything loaded without a valid bit is never shown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op1        <= OP_MUL;
      op2        <= OP_MUL;
      tag1       <= '0;
      tag2       <= '0;
      out_tag    <= '0;
      out_result <= '0;
    end else if (mul_ce) begin
      op1        <= op_in;
      tag1       <= in_tag;
      op2        <= op1;
      tag2       <= tag1;
      out_tag    <= tag2;
      out_result <= (op2 == OP_MUL) ? mul_p[31:0] : mul_p[63:32];
    end
  end

endmodule

// File: tb/tb_mul_issue_unit.sv
// Directed and randomised bench for mul_issue_unit with a behavioural 2-stage multiplier.
module tb_mul_issue_unit;

  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [31:0]      in_rs1, in_rs2;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;
  logic [32:0]      mul_a, mul_b;
  logic             mul_ce;
  logic [65:0]      mul_p;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mul_issue_unit #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag),
    .busy(busy),
    .mul_a(mul_a), .mul_b(mul_b), .mul_ce(mul_ce), .mul_p(mul_p)
  );

  // Behavioural multiplier: signed 33x33, two CE-gated stages, no reset.
  logic [65:0] p1, p2;
  always @(posedge clk) begin
    if (mul_ce) begin
      p1 <= {{33{mul_a[32]}}, mul_a} * {{33{mul_b[32]}}, mul_b};
      p2 <= p1;
    end
  end
  assign mul_p = p2;

  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (op == 2'b11) ? {32'b0, a} : {{32{a[31]}}, a};
    eb = (op[1] == 1'b1) ? {32'b0, b} : {{32{b[31]}}, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [TAG_W-1:0] t);
    in_valid = v; in_op = op; in_rs1 = a; in_rs2 = b; in_tag = t;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %0b exp 0", busy); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
    tests++; if (mul_ce !== 1'b1) begin fails++; $display("FAIL reset_mul_ce got %0b exp 1", mul_ce); end
    tests++; if (out_result !== 32'h0) begin fails++; $display("FAIL reset_out_result got %h exp 0", out_result); end
    tests++; if (out_tag !== '0) begin fails++; $display("FAIL reset_out_tag got %h exp 0", out_tag); end
  endtask

  task automatic test_operands();
    logic [32:0] ea [4];
    logic [32:0] eb [4];
    ea = '{33'h1_8000_0000, 33'h1_8000_0000, 33'h1_8000_0000, 33'h0_8000_0000};
    eb = '{33'h1_8000_0000, 33'h1_8000_0000, 33'h0_8000_0000, 33'h0_8000_0000};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2'(i), 32'h8000_0000, 32'h8000_0000, '0);
      #1;
      tests++; if (mul_a !== ea[i]) begin fails++; $display("FAIL operand_a op%0d got %h exp %h", i, mul_a, ea[i]); end
      tests++; if (mul_b !== eb[i]) begin fails++; $display("FAIL operand_b op%0d got %h exp %h", i, mul_b, eb[i]); end
    end
    tick();
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive(1'b1, 2'b01, 32'h8000_0000, 32'h8000_0000, 5'h13);
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0, '0);
    tests++; if (out_valid !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL single_edge1 got ov=%0b busy=%0b exp ov=0 busy=1", out_valid, busy); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_edge2 got ov=%0b exp 0", out_valid); end
    tick();
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_valid got %0b exp 1", out_valid); end
    tests++; if (out_result !== 32'h4000_0000) begin fails++; $display("FAIL single_result got %h exp 40000000", out_result); end
    tests++; if (out_tag !== 5'h13) begin fails++; $display("FAIL single_tag got %h exp 13", out_tag); end
    tick();
    tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL single_drain got ov=%0b busy=%0b exp 0 0", out_valid, busy); end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  ops [4];
    logic [31:0] exp_r [4];
    ops   = '{2'b00, 2'b01, 2'b11, 2'b10};
    exp_r = '{32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == 0) drive(1'b1, ops[0], 32'h8000_0000, 32'h0000_0002, 5'd1);
      else if (i < 4) drive(1'b1, ops[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'(i + 1));
      else drive(1'b0, 2'b00, 32'h0, 32'h0, '0);
      tick();
      if (i >= 2 && i <= 5) begin
        tests++;
        if (out_valid !== 1'b1 || out_result !== exp_r[i-2] || out_tag !== 5'(i - 1)) begin
          fails++;
          $display("FAIL b2b_result%0d got v=%0b r=%h t=%h exp v=1 r=%h t=%h",
                   i - 2, out_valid, out_result, out_tag, exp_r[i-2], 5'(i - 1));
        end
      end else begin
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_idle%0d got ov=%0b exp 0", i, out_valid); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [1:0]  ops [4];
    logic [31:0] a [4];
    logic [31:0] b [4];
    logic [31:0] exp_r [4];
    ops   = '{2'b00, 2'b01, 2'b10, 2'b11};
    a     = '{32'd3, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 32'h8000_0000};
    b     = '{32'd5, 32'h7FFF_FFFF, 32'h0000_0003, 32'h0000_0004};
    exp_r = '{32'd15, 32'h3FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0002};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ops[i], a[i], b[i], 5'(8'h0A + i));
      tick();
    end
    tests++; if (out_valid !== 1'b1 || out_result !== exp_r[0]) begin fails++; $display("FAIL bp_first got v=%0b r=%h exp v=1 r=%h", out_valid, out_result, exp_r[0]); end
    out_ready = 1'b0;
    drive(1'b1, ops[3], a[3], b[3], 5'h0D);
    #1;
    tests++; if (in_ready !== 1'b0 || mul_ce !== 1'b0) begin fails++; $display("FAIL bp_stall got rdy=%0b ce=%0b exp 0 0", in_ready, mul_ce); end
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if (out_valid !== 1'b1 || out_result !== exp_r[0] || out_tag !== 5'h0A || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold%0d got v=%0b r=%h t=%h rdy=%0b exp v=1 r=%h t=0a rdy=0",
                 i, out_valid, out_result, out_tag, in_ready, exp_r[0]);
      end
    end
    out_ready = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready got %0b exp 1", in_ready); end
    for (int i = 1; i < 4; i++) begin
      tick();
      drive(1'b0, 2'b00, 32'h0, 32'h0, '0);
      tests++;
      if (out_valid !== 1'b1 || out_result !== exp_r[i] || out_tag !== 5'(8'h0A + i)) begin
        fails++;
        $display("FAIL bp_after%0d got v=%0b r=%h t=%h exp v=1 r=%h t=%h",
                 i, out_valid, out_result, out_tag, exp_r[i], 5'(8'h0A + i));
      end
    end
    tick();
    tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL bp_drain got ov=%0b busy=%0b exp 0 0", out_valid, busy); end
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b00, 32'd100 + 32'(i), 32'd2, 5'(8'h10 + i));
      tick();
    end
    // An op offered in the flush cycle must be refused.
    drive(1'b1, 2'b00, 32'd9, 32'd9, 5'h15);
    flush = 1'b1;
    #1;
    tests++; if (out_valid !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL flush_pre got ov=%0b busy=%0b exp 1 1", out_valid, busy); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_in_ready got %0b exp 0", in_ready); end
    tick();
    flush = 1'b0;
    drive(1'b1, 2'b00, 32'd7, 32'd6, 5'h1F);
    #1;
    tests++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL flush_post got ov=%0b busy=%0b rdy=%0b exp 0 0 1", out_valid, busy, in_ready); end
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0, '0);
    for (int i = 0; i < 2; i++) begin
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_stale%0d got ov=%0b exp 0", i, out_valid); end
      tick();
    end
    tests++; if (out_valid !== 1'b1 || out_result !== 32'd42 || out_tag !== 5'h1F) begin fails++; $display("FAIL flush_new got v=%0b r=%h t=%h exp v=1 r=0000002a t=1f", out_valid, out_result, out_tag); end
    tick();
    tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL flush_drain got ov=%0b busy=%0b exp 0 0", out_valid, busy); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b11, 32'hFFFF_FFFF, 32'h1234_5678, 5'(8'h18 + i));
      tick();
    end
    drive(1'b0, 2'b00, 32'h0, 32'h0, '0);
    rst_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rstmid_async got ov=%0b busy=%0b exp 0 0", out_valid, busy); end
    tick();
    rst_n = 1'b1;
    tick();
    tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rstmid_release got ov=%0b busy=%0b exp 0 0", out_valid, busy); end
    drive(1'b1, 2'b11, 32'h0001_0000, 32'h0001_0000, 5'h07);
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0, '0);
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_stale got ov=%0b exp 0", out_valid); end
    tick();
    tests++; if (out_valid !== 1'b1 || out_result !== 32'h1 || out_tag !== 5'h07) begin fails++; $display("FAIL rstmid_op got v=%0b r=%h t=%h exp v=1 r=00000001 t=07", out_valid, out_result, out_tag); end
    tick();
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic [31:0]      result;
    logic [TAG_W-1:0] tag;
  } exp_t;

  task automatic test_random();
    exp_t q[$];
    int   issued = 0;
    int   cycles = 0;
    bit   pend   = 1'b0;
    logic exp_ready;
    logic [1:0] op;
    logic [31:0] a, b;
    while ((issued < 1000 || pend || q.size() != 0 || out_valid) && cycles < 20000) begin
      if (!pend && issued < 1000 && $urandom_range(0, 3) != 0) begin
        op = 2'($urandom_range(0, 3)); a = rand_val(); b = rand_val();
        pend = 1'b1;
      end
      drive(pend, op, a, b, 5'(issued));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = (issued < 1000) && ($urandom_range(0, 49) == 0);
      #1;
      exp_ready = !(out_valid && !out_ready) && !flush;
      if (in_ready !== exp_ready) begin
        tests++; fails++;
        $display("FAIL rand_in_ready cyc%0d got %0b exp %0b", cycles, in_ready, exp_ready);
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL rand_spurious cyc%0d got r=%h t=%h exp no result", cycles, out_result, out_tag);
        end else if (out_ready && !flush) begin
          tests++;
          if (out_result !== q[0].result || out_tag !== q[0].tag) begin
            fails++;
            $display("FAIL rand_result cyc%0d got r=%h t=%h exp r=%h t=%h",
                     cycles, out_result, out_tag, q[0].result, q[0].tag);
          end
          void'(q.pop_front());
        end
      end
      if (flush) q.delete();
      if (pend && exp_ready) begin
        q.push_back('{result: ref_mul(op, a, b), tag: 5'(issued)});
        pend = 1'b0;
        issued++;
      end
      tick();
      cycles++;
    end
    drive(1'b0, 2'b00, 32'h0, 32'h0, '0);
    flush = 1'b0;
    tests++;
    if (cycles >= 20000) begin
      fails++;
      $display("FAIL rand_timeout got issued=%0d pending=%0d exp all drained", issued, q.size());
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 2'b00, 32'h0, 32'h0, '0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    test_reset();
    test_operands();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
